// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types for the commit trace buffer
package pipeline_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int TRACE_ADDR_W = 32;
    localparam int TRACE_DATA_W = 32;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] pc;
        logic                    regWrite;
        logic [REG_ADDR_W-1:0]   writeReg;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        POST    = 2'd1,
        FROZEN  = 2'd2
    } trace_state_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - commit input and first-word-fall-through read port bundle
interface commit_trace_buffer_if
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic                  CommitValid;
    logic [ADDR_W-1:0]     CommitPC;
    logic                  CommitRegWrite;
    logic [REG_ADDR_W-1:0] CommitWriteReg;
    logic [DATA_W-1:0]     CommitWriteData;

    logic                  RdReady;
    logic                  RdValid;
    logic [ADDR_W-1:0]     RdPC;
    logic                  RdRegWrite;
    logic [REG_ADDR_W-1:0] RdWriteReg;
    logic [DATA_W-1:0]     RdWriteData;

    modport master (
        output CommitValid, CommitPC, CommitRegWrite, CommitWriteReg, CommitWriteData, RdReady,
        input  RdValid, RdPC, RdRegWrite, RdWriteReg, RdWriteData
    );

    modport slave (
        input  CommitValid, CommitPC, CommitRegWrite, CommitWriteReg, CommitWriteData, RdReady,
        output RdValid, RdPC, RdRegWrite, RdWriteReg, RdWriteData
    );

endinterface

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 70,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             WrEn,
    input  logic [PTR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic [PTR_W-1:0] RdAddr,
    output logic [WIDTH-1:0] RdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
    end

    assign RdData = mem[RdAddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retired-instruction trace buffer with wrap/stop capture
// and an optional PC trigger enabled by COMMIT_TRACE_TRIGGER_EN.
module commit_trace_buffer
    import pipeline_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int POST_TRIG = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Mode,
    input  logic                   Arm,
    input  logic [ADDR_W-1:0]      TrigPC,
    commit_trace_buffer_if.slave   bus,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow,
    output logic                   Frozen,
    output logic [ADDR_W-1:0]      PCDisplay,
    output logic [DATA_W-1:0]      WriteDataDisplay
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0]     pc;
        logic                  regWrite;
        logic [REG_ADDR_W-1:0] writeReg;
        logic [DATA_W-1:0]     data;
    } entry_t;

    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic             captureOn, push, pop, full, wrEn;
    entry_t           wrEntry, rdEntry;

    assign full        = (Count == FULL_COUNT);
    assign bus.RdValid = (Count != '0);
    assign push        = bus.CommitValid && captureOn;
    assign pop         = bus.RdValid && bus.RdReady;
    // Only a stop-mode push into a full buffer with no pop is dropped.
    assign wrEn        = push && !(full && !pop && Mode);

    assign wrEntry = '{pc: bus.CommitPC, regWrite: bus.CommitRegWrite,
                       writeReg: bus.CommitWriteReg, data: bus.CommitWriteData};

    trace_ram #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) ram (
        .Clk    (Clk),
        .WrEn   (wrEn),
        .WrAddr (wrPtr),
        .WrData (wrEntry),
        .RdAddr (rdPtr),
        .RdData (rdEntry)
    );

    assign bus.RdPC        = rdEntry.pc;
    assign bus.RdRegWrite  = rdEntry.regWrite;
    assign bus.RdWriteReg  = rdEntry.writeReg;
    assign bus.RdWriteData = rdEntry.data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wrPtr            <= '0;
            rdPtr            <= '0;
            Count            <= '0;
            Overflow         <= 1'b0;
            PCDisplay        <= '0;
            WriteDataDisplay <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + ONE_PTR;
            end
            // A wrap-mode overwrite retires the oldest entry just like a pop.
            if (pop || (wrEn && full)) begin
                rdPtr <= rdPtr + ONE_PTR;
            end
            if (wrEn && !pop && !full) begin
                Count <= Count + ONE_CNT;
            end else if (pop && !wrEn) begin
                Count <= Count - ONE_CNT;
            end
            if (push && full && !pop) begin
                Overflow <= 1'b1;
            end else if (Arm) begin
                Overflow <= 1'b0;
            end
            if (bus.CommitValid) begin
                PCDisplay        <= bus.CommitPC;
                WriteDataDisplay <= bus.CommitWriteData;
            end
        end
    end

`ifdef COMMIT_TRACE_TRIGGER_EN
    localparam logic [PTR_W-1:0] POST_LOAD = PTR_W'(POST_TRIG);

    trace_state_t     state, stateNext;
    logic             armed, armedNext;
    logic [PTR_W-1:0] postCnt, postCntNext;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= CAPTURE;
            armed   <= 1'b0;
            postCnt <= '0;
        end else begin
            state   <= stateNext;
            armed   <= armedNext;
            postCnt <= postCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        armedNext   = armed;
        postCntNext = postCnt;
        unique case (state)
            CAPTURE: begin
                if (push && armed && (bus.CommitPC == TrigPC)) begin
                    armedNext   = 1'b0;
                    postCntNext = POST_LOAD;
                    stateNext   = (POST_LOAD == '0) ? FROZEN : POST;
                end
            end
            POST: begin
                if (push) begin
                    postCntNext = postCnt - ONE_PTR;
                    if (postCnt == ONE_PTR) begin
                        stateNext = FROZEN;
                    end
                end
            end
            FROZEN: begin
                if (Arm) begin
                    stateNext = CAPTURE;
                end
            end
            default: stateNext = CAPTURE;
        endcase
        // Applied after the trigger check so a same-cycle match sees the old flag.
        if (Arm) begin
            armedNext = 1'b1;
        end
    end

    assign captureOn = (state != FROZEN);
    assign Frozen    = (state == FROZEN);
`else
    logic unusedTrig;
    assign unusedTrig = (^TrigPC) ^ (POST_TRIG > 0);
    assign captureOn  = 1'b1;
    assign Frozen     = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - scoreboard bench; COMMIT_TRACE_TRIGGER_EN selects trigger expectations
module tb_commit_trace_buffer;
    import pipeline_pkg::*;

    logic        Clk    = 1'b0;
    logic        Reset  = 1'b1;
    logic        Mode   = 1'b0;
    logic        Arm    = 1'b0;
    logic [31:0] TrigPC = 32'hFFFF_FFF0;
    logic [2:0]  Count;
    logic        Overflow, Frozen;
    logic [31:0] PCDisplay, WriteDataDisplay;

    int nVec = 0;
    int nMis = 0;
    trace_entry_t expQ[$];

    commit_trace_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    commit_trace_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .POST_TRIG(2)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Mode             (Mode),
        .Arm              (Arm),
        .TrigPC           (TrigPC),
        .bus              (bus),
        .Count            (Count),
        .Overflow         (Overflow),
        .Frozen           (Frozen),
        .PCDisplay        (PCDisplay),
        .WriteDataDisplay (WriteDataDisplay)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] dflt(logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic trace_entry_t mk(logic [31:0] pc, logic [31:0] data);
        trace_entry_t e;
        e.pc       = pc;
        e.regWrite = pc[2];
        e.writeReg = pc[6:2];
        e.data     = data;
        return e;
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic commit(logic [31:0] pc, logic [31:0] data, bit willRead);
        trace_entry_t e;
        e = mk(pc, data);
        bus.CommitValid     = 1'b1;
        bus.CommitPC        = e.pc;
        bus.CommitRegWrite  = e.regWrite;
        bus.CommitWriteReg  = e.writeReg;
        bus.CommitWriteData = e.data;
        if (willRead) expQ.push_back(e);
        cyc();
        bus.CommitValid = 1'b0;
    endtask

    task automatic pulseArm();
        Arm = 1'b1;
        cyc();
        Arm = 1'b0;
    endtask

    task automatic drain(string tag);
        bus.RdReady = 1'b1;
        for (int i = 0; i < 12 && bus.RdValid; i++) cyc();
        bus.RdReady = 1'b0;
        chk({tag, "_empty"}, 32'(bus.RdValid), 32'd0);
        chk({tag, "_pending"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    initial begin
        trace_entry_t got, want;
        forever begin
            @(negedge Clk);
            if (bus.RdValid && bus.RdReady) begin
                got = '{pc: bus.RdPC, regWrite: bus.RdRegWrite,
                        writeReg: bus.RdWriteReg, data: bus.RdWriteData};
                nVec++;
                if (expQ.size() == 0) begin
                    nMis++;
                    $display("FAIL rd_unexpected: got pc %0h, expected no entry", got.pc);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) begin
                        nMis++;
                        $display("FAIL rd_entry: got %h, expected %h", got, want);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CommitValid     = 1'b0;
        bus.CommitPC        = '0;
        bus.CommitRegWrite  = 1'b0;
        bus.CommitWriteReg  = '0;
        bus.CommitWriteData = '0;
        bus.RdReady         = 1'b0;
        #12 Reset = 1'b0;
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_rdvalid", 32'(bus.RdValid), 32'd0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        chk("rst_frozen", 32'(Frozen), 32'd0);
        chk("rst_pcdisp", PCDisplay, 32'd0);
        chk("rst_wddisp", WriteDataDisplay, 32'd0);
        cyc();

        // Wrap mode: six commits into four entries keep the newest four.
        Mode = 1'b0;
        for (int i = 0; i < 6; i++) commit(32'(i * 4), dflt(32'(i * 4)), i >= 2);
        chk("wrap_count", 32'(Count), 32'd4);
        chk("wrap_overflow", 32'(Overflow), 32'd1);
        drain("wrap");
        pulseArm();
        chk("arm_clr_ovf1", 32'(Overflow), 32'd0);

        // Stop mode: the first four are kept, the rest dropped.
        Mode = 1'b1;
        for (int i = 0; i < 6; i++) commit(32'(i * 4), dflt(32'(i * 4)), i < 4);
        chk("stop_count", 32'(Count), 32'd4);
        chk("stop_overflow", 32'(Overflow), 32'd1);
        drain("stop");
        pulseArm();
        chk("arm_clr_ovf2", 32'(Overflow), 32'd0);

        // Full buffer with a simultaneous push and pop.
        Mode = 1'b0;
        for (int i = 0; i < 4; i++) commit(32'h100 + 32'(i * 4), dflt(32'h100 + 32'(i * 4)), 1'b1);
        chk("full_count", 32'(Count), 32'd4);
        bus.RdReady = 1'b1;
        commit(32'h40, dflt(32'h40), 1'b1);
        bus.RdReady = 1'b0;
        chk("pushpop_count", 32'(Count), 32'd4);
        chk("pushpop_overflow", 32'(Overflow), 32'd0);
        drain("pushpop");

        // Display registers.
        commit(32'h30, 32'hDEADBEEF, 1'b1);
        chk("disp_pc", PCDisplay, 32'h30);
        chk("disp_data", WriteDataDisplay, 32'hDEADBEEF);
        drain("disp");

        // Trigger window.
        TrigPC = 32'h20;
        pulseArm();
        for (int i = 0; i < 6; i++) begin
`ifdef COMMIT_TRACE_TRIGGER_EN
            commit(32'h18 + 32'(i * 4), dflt(32'h18 + 32'(i * 4)), i >= 1 && i <= 4);
            if (i == 3) chk("trig_not_frozen", 32'(Frozen), 32'd0);
            if (i == 4) chk("trig_frozen", 32'(Frozen), 32'd1);
`else
            commit(32'h18 + 32'(i * 4), dflt(32'h18 + 32'(i * 4)), i >= 2);
            if (i == 4) chk("trig_frozen", 32'(Frozen), 32'd0);
`endif
        end
        chk("trig_count", 32'(Count), 32'd4);
        chk("trig_disp_pc", PCDisplay, 32'h2C);
        chk("trig_disp_data", WriteDataDisplay, dflt(32'h2C));
        drain("trig");
        pulseArm();
        chk("rearm_frozen", 32'(Frozen), 32'd0);
        commit(32'h60, dflt(32'h60), 1'b1);
        chk("rearm_count", 32'(Count), 32'd1);
        drain("rearm");

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) commit(32'h80 + 32'(i * 4), dflt(32'h80 + 32'(i * 4)), 1'b0);
        chk("pre_rst_count", 32'(Count), 32'd3);
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(Count), 32'd0);
        chk("async_rst_rdvalid", 32'(bus.RdValid), 32'd0);
        chk("async_rst_pcdisp", PCDisplay, 32'd0);
        #10 Reset = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
